// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver byte feed plus peripheral bus view of the rx fifo
interface uart_rx_fifo_if;
  logic        RxValid;
  logic [7:0]  RxByte;
  logic [31:0] Addr;
  logic        Read;
  logic        Write;
  logic [31:0] WData;
  logic [31:0] RxData;
  logic [31:0] StatData;
  logic        Irq;
  modport master(output RxValid, RxByte, Addr, Read, Write, WData, input RxData, StatData, Irq);
  modport slave(input RxValid, RxByte, Addr, Read, Write, WData, output RxData, StatData, Irq);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular byte fifo between the serial receiver and the cpu bus
module uart_rx_fifo #(
  parameter int          DEPTH     = 16,
  parameter int          ADDR_W    = 4,
  parameter int          THRESH    = 1,
  parameter logic [31:0] DATA_ADDR = 32'h4000_001C,
  parameter logic [31:0] STAT_ADDR = 32'h4000_0024
) (
  input logic           C,
  input logic           R,
  uart_rx_fifo_if.slave bus
);
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [ADDR_W:0]   count;
  logic              overflow, rx_valid_d;
  logic              empty, full, push_req, pop_req, push_ok, pop_ok, drop, clr;
  logic              wdata_unused;
  assign wdata_unused = ^bus.WData[31:1];
  assign empty    = count == '0;
  assign full     = count == (ADDR_W+1)'(DEPTH);
  assign push_req = bus.RxValid & ~rx_valid_d;
  assign pop_req  = bus.Read & (bus.Addr == DATA_ADDR);
  assign pop_ok   = pop_req & ~empty;
  assign push_ok  = push_req & (~full | pop_ok);
  assign drop     = push_req & ~push_ok;
  assign clr      = bus.Write & (bus.Addr == STAT_ADDR) & bus.WData[0];
  // head is combinational so the cpu captures it in the same cycle as the pop strobe
  assign bus.RxData   = empty ? 32'b0 : {24'b0, mem[rd_ptr]};
  assign bus.StatData = {13'b0, overflow, full, empty, 16'(count)};
  assign bus.Irq      = count >= (ADDR_W+1)'(THRESH);
  always_ff @(posedge C) begin
    if (R) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      rx_valid_d <= 1'b0;
    end else begin
      rx_valid_d <= bus.RxValid;
      if (push_ok) begin
        mem[wr_ptr] <= bus.RxByte;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count    <= (push_ok & ~pop_ok) ? count + 1'b1 : (pop_ok & ~push_ok) ? count - 1'b1 : count;
      overflow <= drop | (overflow & ~clr);
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scoreboard bench for uart_rx_fifo (THRESH=1 and THRESH=4 instances)
module tb_uart_rx_fifo;
  localparam logic [31:0] DATA_ADDR = 32'h4000_001C;
  localparam logic [31:0] STAT_ADDR = 32'h4000_0024;
  logic C = 1'b0;
  logic R = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [7:0] sb [$];
  logic ovf = 1'b0;
  uart_rx_fifo_if b ();
  uart_rx_fifo_if b4 ();
  assign b4.RxValid = b.RxValid;
  assign b4.RxByte  = b.RxByte;
  assign b4.Addr    = b.Addr;
  assign b4.Read    = b.Read;
  assign b4.Write   = b.Write;
  assign b4.WData   = b.WData;
  uart_rx_fifo dut (.C(C), .R(R), .bus(b.slave));
  uart_rx_fifo #(.THRESH(4)) dut4 (.C(C), .R(R), .bus(b4.slave));
  always #5 C = ~C;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic check_state(input string tag);
    int n;
    n = sb.size();
    chk({tag, "_rxdata"}, b.RxData, n == 0 ? 32'b0 : {24'b0, sb[0]});
    chk({tag, "_stat"}, b.StatData, {13'b0, ovf, n == 16, n == 0, 16'(n)});
    chk({tag, "_irq"}, {31'b0, b.Irq}, {31'b0, n >= 1});
    chk({tag, "_irq4"}, {31'b0, b4.Irq}, {31'b0, n >= 4});
  endtask
  task automatic push(input logic [7:0] v, input bit stored);
    b.RxValid = 1'b1;
    b.RxByte  = v;
    @(negedge C);
    b.RxValid = 1'b0;
    @(negedge C);
    if (stored) sb.push_back(v);
    else ovf = 1'b1;
  endtask
  task automatic pop(input string tag);
    b.Read = 1'b1;
    b.Addr = DATA_ADDR;
    chk(tag, b.RxData, sb.size() == 0 ? 32'b0 : {24'b0, sb.pop_front()});
    @(negedge C);
    b.Read = 1'b0;
  endtask
  task automatic stat_write(input logic [31:0] v);
    b.Write = 1'b1;
    b.Addr  = STAT_ADDR;
    b.WData = v;
    @(negedge C);
    b.Write = 1'b0;
    b.WData = 32'b0;
  endtask
  initial begin
    b.RxValid = 1'b0;
    b.RxByte  = 8'h00;
    b.Addr    = 32'b0;
    b.Read    = 1'b0;
    b.Write   = 1'b0;
    b.WData   = 32'b0;
    repeat (2) @(negedge C);
    R = 1'b0;
    check_state("reset");
    push(8'h41, 1'b1);
    chk("t1_data", b.RxData, 32'h41);
    chk("t1_stat", b.StatData, 32'h0000_0001);
    check_state("t1_push");
    pop("t1_pop");
    check_state("t1_empty");
    b.RxValid = 1'b1;
    b.RxByte  = 8'h55;
    repeat (5) @(negedge C);
    b.RxValid = 1'b0;
    @(negedge C);
    sb.push_back(8'h55);
    check_state("t2_hold");
    pop("t2_pop");
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    chk("t3_full_stat", b.StatData, 32'h0002_0010);
    push(8'hAA, 1'b0);
    chk("t3_ovf_stat", b.StatData, 32'h0006_0010);
    check_state("t3_ovf");
    for (int i = 0; i < 16; i++) pop("t3_drain");
    check_state("t3_empty_ovf");
    stat_write(32'h0);
    check_state("t3_wr0_keeps");
    b.Write = 1'b1;
    b.Addr  = DATA_ADDR;
    b.WData = 32'h1;
    @(negedge C);
    b.Write = 1'b0;
    check_state("t3_wrdata_keeps");
    stat_write(32'h1);
    ovf = 1'b0;
    check_state("t3_clear");
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    b.RxValid = 1'b1;
    b.RxByte  = 8'hBB;
    b.Read    = 1'b1;
    b.Addr    = DATA_ADDR;
    chk("t4_head", b.RxData, {24'b0, sb.pop_front()});
    sb.push_back(8'hBB);
    @(negedge C);
    b.RxValid = 1'b0;
    b.Read    = 1'b0;
    @(negedge C);
    check_state("t4_full_pushpop");
    for (int i = 0; i < 15; i++) pop("t4_drain");
    chk("t4_last", b.RxData, 32'hBB);
    pop("t4_last_pop");
    for (int i = 0; i < 10; i++) push(8'h30 + 8'(i), 1'b1);
    for (int i = 0; i < 10; i++) pop("t5_pop_a");
    for (int i = 0; i < 10; i++) push(8'h20 + 8'(i), 1'b1);
    check_state("t5_wrapped");
    for (int i = 0; i < 10; i++) pop("t5_pop_b");
    pop("t5_empty_read");
    check_state("t5_after_empty_read");
    b.RxValid = 1'b1;
    b.RxByte  = 8'h5A;
    b.Read    = 1'b1;
    b.Addr    = DATA_ADDR;
    chk("t5_empty_pushpop_rd", b.RxData, 32'h0);
    @(negedge C);
    b.RxValid = 1'b0;
    b.Read    = 1'b0;
    sb.push_back(8'h5A);
    @(negedge C);
    check_state("t5_empty_pushpop");
    pop("t5_pop_5a");
    for (int i = 0; i < 3; i++) push(8'h60 + 8'(i), 1'b1);
    check_state("t6_loaded");
    b.RxValid = 1'b1;
    b.RxByte  = 8'h77;
    R = 1'b1;
    @(negedge C);
    R = 1'b0;
    b.RxValid = 1'b0;
    sb.delete();
    @(negedge C);
    check_state("t6_reset");
    for (int i = 0; i < 4; i++) begin
      push(8'h70 + 8'(i), 1'b1);
      check_state("t6_thresh_up");
    end
    pop("t6_pop");
    check_state("t6_thresh_down");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer between the 9600-baud serial receiver and the CPU-visible UART register bank. It captures each completed byte from the receiver's valid/data outputs into a circular FIFO. It exposes the head byte and status on the memory-mapped peripheral bus, so software can drain bursts without losing characters between polls. It pops on CPU reads of its data address and raises a level interrupt request while data is pending.

Parameters:
DEPTH, 16, number of byte entries; power of two, 2..256
ADDR_W, 4, log2(DEPTH); pointer width
THRESH, 1, Irq asserted while Count >= THRESH; range 1..DEPTH
DATA_ADDR, 32'h4000_001C, bus address; a read pops the FIFO
STAT_ADDR, 32'h4000_0024, bus address of the status word; a write clears sticky flags

Ports:
C  input  1  system clock; all state updates on rising edge
R  input  1  reset; synchronous, active-high
RxValid  input  1  byte-complete indication from receiver; may stay high for more than one cycle
RxByte  input  8  received byte; stable while RxValid is high
Addr  input  32  peripheral bus address
Read  input  1  bus read strobe, one cycle per access
Write  input  1  bus write strobe, one cycle per access
WData  input  32  bus write data
RxData  output  32  {24'b0, head byte}; 32'b0 when empty
StatData  output  32  [15:0]=Count zero-extended, [16]=Empty, [17]=Full, [18]=Overflow, [31:19]=0
Irq  output  1  level interrupt request

Behaviour:
- Reset (R=1 at a rising edge of C): rd_ptr=0, wr_ptr=0, Count=0, Overflow=0, RxValid_d=0. Outputs: RxData=0, StatData=32'h0001_0000 (Empty=1), Irq=0. The memory array is not cleared; its contents are unobservable while Empty.
- Reset mid-operation discards all buffered bytes and any in-flight push or pop that same cycle.
- Push detection:
  - RxValid_d is a registered copy of RxValid.
  - push_req = RxValid & ~RxValid_d, i.e. exactly one push per rising edge of RxValid.
  - A held-high RxValid does not push again.
- Pop detection: pop_req = Read & (Addr==DATA_ADDR).
- Qualification: push_ok = push_req & (~Full | pop_ok); pop_ok = pop_req & ~Empty.
- Push: mem[wr_ptr] <= RxByte; wr_ptr <= wr_ptr+1. Pointer arithmetic is modulo DEPTH; ADDR_W-bit pointers wrap naturally.
- Pop: rd_ptr <= rd_ptr+1.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. Count width is ADDR_W+1 and never exceeds DEPTH.
- Simultaneous push and pop when Full: both execute. The head leaves, the new byte enters, and Count stays DEPTH.
- Simultaneous push and pop when Empty: the pop is ignored and the push executes (Count becomes 1).
- Push when Full without a pop: the byte is dropped, Overflow <= 1 (sticky), and pointers and Count are unchanged.
- Pop when Empty: ignored, with no pointer change and no flag change. RxData reads 0.
- Overflow clear:
  - Write & (Addr==STAT_ADDR) & WData[0] clears Overflow.
  - If a drop occurs in the same cycle as the clear, set wins: Overflow stays 1.
- Writes to DATA_ADDR, and writes to STAT_ADDR with WData[0]=0, have no effect.
- Read timing:
  - RxData is combinational from mem[rd_ptr] gated by ~Empty, so the CPU samples the head in the same cycle as the pop strobe.
  - The next head appears the cycle after the pop edge.
- Flags: Empty = (Count==0); Full = (Count==DEPTH); both are derived combinationally from the registered Count.
- Irq = (Count >= THRESH), derived from registered Count and therefore glitch-free. It deasserts the cycle after the pop that takes Count below THRESH.
- Latency: a byte whose RxValid rises at edge n is sampled at edge n+1. It is visible on RxData, StatData and Irq after edge n+1 when the FIFO was empty.
- No other state or states: this is a pointer/count datapath only, with no FSM beyond the edge detector.

Test Plan:
1. Reset, then pulse RxValid with RxByte=8'h41 -> next cycle RxData=32'h41, StatData=32'h0000_0001, Irq=1. Read DATA_ADDR -> RxData=0, StatData=32'h0001_0000, Irq=0.
2. Hold RxValid high for 5 cycles with RxByte=8'h55 -> exactly one push: Count=1, RxData=32'h55.
3. Push 16 bytes 8'h00..8'h0F -> Full=1, StatData=32'h0002_0010. Push 8'hAA -> dropped, Overflow=1, StatData=32'h0006_0010. Pop 16 times -> bytes 00..0F in order, then Empty=1 with Overflow still 1. Write STAT_ADDR with WData=1 -> Overflow=0.
4. FIFO full with head 8'h00; same cycle push 8'hBB and Read DATA_ADDR -> RxData shows 8'h00 in that cycle, Count stays 16, Overflow stays 0, and the last entry popped is 8'hBB.
5. Wrap: push 10 bytes, pop 10, then push 10 more (8'h20..8'h29) -> pop sequence is 20..29 with no corruption across the pointer wrap. Read DATA_ADDR while Empty -> no state change.
6. Load 3 bytes, assert R=1 for one cycle during a concurrent push -> afterwards Count=0, Empty=1, Irq=0, RxData=0. With THRESH=4: Irq rises only after the 4th push and falls after the pop that returns Count to 3.
